// File: rtl/tisc_ctrl.sv
// tisc_ctrl: IF/ID/EX/MEM/WB control sequencer with halt, illegal-opcode and retire tracking.
// Optional TISC_CTRL_ILLEGAL_TRAP_EN makes illegal opcodes halt instead of running as NOP.
module tisc_ctrl #(
  parameter int RETIRE_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          opcode,
  input  logic                stall,
  output logic [1:0]          alu_sel,
  output logic                reg_write_en,
  output logic                mem_write_en,
  output logic                mem_to_reg,
  output logic                mem_op,
  output logic                pc_en,
  output logic                halted,
  output logic                illegal,
  output logic [RETIRE_W-1:0] retired
);
  typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT} state_t;
  state_t state, state_n;
  logic [3:0] op_q;
  logic ill_live, go_halt, exec;
  assign ill_live = opcode inside {[4'h7:4'hE]};
`ifdef TISC_CTRL_ILLEGAL_TRAP_EN
  assign go_halt = (opcode == 4'hF) || ill_live;
`else
  assign go_halt = opcode == 4'hF;
`endif
  always_comb begin
    state_n = state;
    case (state)
      S_IF:    state_n = S_ID;
      S_ID:    state_n = go_halt ? S_HALT : S_EX;
      S_EX:    state_n = S_MEM;
      S_MEM:   state_n = S_WB;
      S_WB:    state_n = S_IF;
      default: state_n = S_HALT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IF;
      op_q    <= 4'h0;
      illegal <= 1'b0;
      retired <= '0;
    end else if (!stall) begin
      state <= state_n;
      if (state == S_ID) begin
        op_q    <= opcode;
        illegal <= illegal | ill_live;
      end
      if (state == S_WB) retired <= retired + RETIRE_W'(1);
    end
  end
  // Strobes are a pure decode of state and op_q, so a stall freezes them for free.
  assign exec         = state inside {S_EX, S_MEM, S_WB};
  assign alu_sel      = (exec && op_q inside {[4'h1:4'h4]}) ? op_q[1:0] - 2'd1 : 2'b00;
  assign mem_op       = exec && (op_q == 4'h5 || op_q == 4'h6);
  assign mem_to_reg   = exec && op_q == 4'h5;
  assign mem_write_en = state == S_MEM && op_q == 4'h6;
  assign reg_write_en = state == S_WB && op_q inside {[4'h1:4'h5]};
  assign pc_en        = state == S_WB;
  assign halted       = state == S_HALT;
endmodule

// File: tb/tb_tisc_ctrl.sv
// tb_tisc_ctrl: scoreboard bench; driver queues per-cycle expected outputs, monitor compares at negedge.
module tb_tisc_ctrl;
  logic clk = 0, rst_n = 0, stall = 0;
  logic [3:0] opcode = 0;
  logic [1:0] alu_sel;
  logic reg_write_en, mem_write_en, mem_to_reg, mem_op, pc_en, halted, illegal;
  logic [7:0] retired;
  tisc_ctrl #(.RETIRE_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .stall(stall),
    .alu_sel(alu_sel), .reg_write_en(reg_write_en), .mem_write_en(mem_write_en),
    .mem_to_reg(mem_to_reg), .mem_op(mem_op), .pc_en(pc_en),
    .halted(halted), .illegal(illegal), .retired(retired)
  );
  always #5 clk = ~clk;
`ifdef TISC_CTRL_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  logic [16:0] exp_q[$];
  string name_q[$];
  int checks = 0, failures = 0;
  logic [7:0] ret_m = 0;
  logic ill_m = 0;
  string tag = "reset";
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [16:0] e, a;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = {alu_sel, reg_write_en, mem_write_en, mem_to_reg, mem_op, pc_en, halted, illegal, retired};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL %s t=%0t got{alu,rw,mw,m2r,mop,pc,hlt,ill,ret}=%h expected=%h", n, $time, a, e);
      end
    end
  end
  function automatic bit is_ill(input logic [3:0] op);
    return op >= 4'h7 && op <= 4'hE;
  endfunction
  // Hand table per opcode: {alu_sel, mem_to_reg, mem_op, writes_reg, writes_mem}
  function automatic logic [5:0] op_tab(input logic [3:0] op);
    case (op)
      4'h1: return 6'b00_0_0_1_0;
      4'h2: return 6'b01_0_0_1_0;
      4'h3: return 6'b10_0_0_1_0;
      4'h4: return 6'b11_0_0_1_0;
      4'h5: return 6'b00_1_1_1_0;
      4'h6: return 6'b00_0_1_0_1;
      default: return 6'b00_0_0_0_0;
    endcase
  endfunction
  function automatic logic [16:0] model(input logic [3:0] op, input int ph, input bit hlt);
    logic [5:0] t;
    bit ex;
    t = op_tab(op);
    ex = (ph >= 2) && !hlt;
    return {ex ? t[5:4] : 2'b00, (ph == 4) && t[1], (ph == 3) && t[0], ex && t[3], ex && t[2],
            ph == 4, hlt, ill_m, ret_m};
  endfunction
  task automatic push(input logic [16:0] e);
    exp_q.push_back(e);
    name_q.push_back(tag);
  endtask
  task automatic step;
    @(posedge clk);
    #2;
  endtask
  task automatic do_reset;
    rst_n = 0;
    stall = 1;
    step;
    rst_n = 1;
    stall = 0;
    ret_m = 0;
    ill_m = 0;
  endtask
  task automatic halt_seq;
    for (int i = 0; i < 6; i++) begin
      push(model(4'hF, 0, 1'b1));
      stall = 1'($urandom_range(0, 1));
      opcode = 4'($urandom_range(0, 15));
      step;
    end
    do_reset;
  endtask
  // sph/sn: stall sn cycles in phase sph; aph: assert reset during phase aph
  task automatic instr(input logic [3:0] op, input int sph, input int sn, input int aph);
    for (int ph = 0; ph < 5; ph++) begin
      for (int k = 0; k <= ((ph == sph) ? sn : 0); k++) begin
        push(model(op, ph, 1'b0));
        if (ph == aph) begin
          do_reset;
          return;
        end
        opcode = (ph == 1) ? op : ~op;
        stall = (ph == sph) && (k < sn);
        step;
      end
      if (ph == 1) begin
        ill_m = ill_m | is_ill(op);
        if (op == 4'hF || (TRAP && is_ill(op))) begin
          halt_seq;
          return;
        end
      end
    end
    ret_m = ret_m + 8'd1;
  endtask
  initial begin
    do_reset;
    tag = "add_x3";
    repeat (3) instr(4'h1, -1, 0, -1);
    tag = "store";
    instr(4'h6, -1, 0, -1);
    tag = "load_stall_ex";
    instr(4'h5, 2, 3, -1);
    tag = "alu_ops";
    instr(4'h2, -1, 0, -1);
    instr(4'h3, -1, 0, -1);
    instr(4'h4, 3, 1, -1);
    tag = "nop_stall_if";
    instr(4'h0, 0, 2, -1);
    tag = "store_stall_wb";
    instr(4'h6, 4, 2, -1);
    tag = "illegal_1010";
    instr(4'hA, -1, 0, -1);
    instr(4'h1, -1, 0, -1);
    tag = "halt";
    do_reset;
    instr(4'h1, -1, 0, -1);
    instr(4'hF, -1, 0, -1);
    tag = "after_halt_reset";
    instr(4'h2, -1, 0, -1);
    tag = "retire_wrap";
    do_reset;
    repeat (255) instr(4'h0, -1, 0, -1);
    instr(4'h1, -1, 0, -1);
    tag = "reset_in_store_mem";
    instr(4'h6, -1, 0, 3);
    tag = "final";
    instr(4'h5, -1, 0, -1);
    push(model(4'h0, 0, 1'b0));
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d pending expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
